// File: rtl/weight_ram_loader_pkg.sv
// Shared CNN datapath constants and the weight loader state encoding.
package weight_ram_loader_pkg;

  localparam int CNN_DATA_WIDTH              = 16;
  localparam int CNN_KERNEL_SIZE_MAX         = 3;
  localparam int CNN_PARA_KERNEL             = 4;
  localparam int CNN_WEIGHT_WRITE_ADDR_WIDTH = 4;
  localparam int CNN_WEIGHT_RAM_DEPTH        = 128;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_ACK   = 2'd2
  } state_t;

  // Width of a counter that walks 0 .. kk-1; never narrower than one bit.
  function automatic int kcnt_width(input int kk);
    return (kk > 1) ? $clog2(kk) : 1;
  endfunction

endpackage

// File: rtl/weight_bank_addr_gen.sv
// Per-bank word address (slot*KK + k) and slot range check.
// The multiply-add runs one bit wider than the largest possible result so the
// range check sees the true end of the slot rather than a wrapped value.
module weight_bank_addr_gen #(
  parameter int WEIGHT_WRITE_ADDR_WIDTH = 4,
  parameter int KK                      = 9,
  parameter int KW                      = 4,
  parameter int WEIGHT_RAM_DEPTH        = 128,
  parameter int WEIGHT_RAM_ADDR_WIDTH   = 7
) (
  input  logic [WEIGHT_WRITE_ADDR_WIDTH-1:0] slot,
  input  logic [KW-1:0]                      k,
  output logic [WEIGHT_RAM_ADDR_WIDTH-1:0]   addr,
  output logic                               in_range
);

  localparam int SW = WEIGHT_WRITE_ADDR_WIDTH + $clog2(KK) + 1;

  logic [SW-1:0] base;
  logic [SW-1:0] span_end;

  assign base     = SW'(slot) * SW'(KK);
  assign span_end = base + SW'(KK);
  assign in_range = (int'(span_end) <= WEIGHT_RAM_DEPTH);
  assign addr     = WEIGHT_RAM_ADDR_WIDTH'(base + SW'(k));

endmodule

// File: rtl/weight_ram_loader.sv
// Captures one weight bundle on a done/ready handshake and serialises it into
// PARA_KERNEL weight-RAM banks, one word per bank per cycle.
// State | meaning
// IDLE  | waiting for weight_data_done; bundle is captured on the accepting edge
// WRITE | word k of every in-range bank is written, k = 0 .. KK-1
// ACK   | init_weight_ram_ready held until weight_data_done is seen low
module weight_ram_loader
  import weight_ram_loader_pkg::*;
#(
  parameter int DATA_WIDTH              = CNN_DATA_WIDTH,
  parameter int KERNEL_SIZE_MAX         = CNN_KERNEL_SIZE_MAX,
  parameter int PARA_KERNEL             = CNN_PARA_KERNEL,
  parameter int WEIGHT_WRITE_ADDR_WIDTH = CNN_WEIGHT_WRITE_ADDR_WIDTH,
  parameter int WEIGHT_RAM_DEPTH        = CNN_WEIGHT_RAM_DEPTH,
  parameter int WEIGHT_RAM_ADDR_WIDTH   = $clog2(WEIGHT_RAM_DEPTH)
) (
  input  logic                                                          clk,
  input  logic                                                          rst,
  input  logic [KERNEL_SIZE_MAX*KERNEL_SIZE_MAX*PARA_KERNEL*DATA_WIDTH-1:0] weight_data,
  input  logic [WEIGHT_WRITE_ADDR_WIDTH*PARA_KERNEL-1:0]                write_weight_data_addr,
  input  logic                                                          weight_data_done,
  output logic                                                          init_weight_ram_ready,
  output logic [PARA_KERNEL-1:0]                                        weight_ram_we,
  output logic [WEIGHT_RAM_ADDR_WIDTH*PARA_KERNEL-1:0]                  weight_ram_addr,
  output logic [DATA_WIDTH*PARA_KERNEL-1:0]                             weight_ram_wdata,
  output logic                                                          busy,
  output logic                                                          addr_err
);

  localparam int KK = KERNEL_SIZE_MAX * KERNEL_SIZE_MAX;
  localparam int KW = kcnt_width(KK);

  state_t state, state_nxt;
  logic [KW-1:0] k;
  logic          last_k;
  logic          in_write;
  logic [KK*PARA_KERNEL*DATA_WIDTH-1:0]          data_q;
  logic [WEIGHT_WRITE_ADDR_WIDTH*PARA_KERNEL-1:0] slot_q;
  logic [WEIGHT_RAM_ADDR_WIDTH-1:0]              bank_addr [PARA_KERNEL];
  logic [PARA_KERNEL-1:0]                        bank_ok;

  assign last_k   = (k == KW'(KK - 1));
  assign in_write = (state == S_WRITE);

  // State register; reset abandons any partial load at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state plus the handshake/status outputs decoded from state.
  always_comb begin
    state_nxt             = state;
    init_weight_ram_ready = 1'b0;
    busy                  = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (weight_data_done) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (last_k) state_nxt = S_ACK;
      end
      S_ACK: begin
        init_weight_ram_ready = 1'b1;
        if (!weight_data_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bundle capture (IDLE only) and the word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      slot_q <= '0;
      k      <= '0;
    end else if (state == S_IDLE && weight_data_done) begin
      data_q <= weight_data;
      slot_q <= write_weight_data_addr;
      k      <= '0;
    end else if (in_write) begin
      k <= k + 1'b1;
    end
  end

  // Sticky flag for any bank whose slot runs past the end of the RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    addr_err <= 1'b0;
    else if (in_write && !(&bank_ok)) addr_err <= 1'b1;
  end

  for (genvar p = 0; p < PARA_KERNEL; p++) begin : g_bank
    weight_bank_addr_gen #(
      .WEIGHT_WRITE_ADDR_WIDTH(WEIGHT_WRITE_ADDR_WIDTH),
      .KK                     (KK),
      .KW                     (KW),
      .WEIGHT_RAM_DEPTH       (WEIGHT_RAM_DEPTH),
      .WEIGHT_RAM_ADDR_WIDTH  (WEIGHT_RAM_ADDR_WIDTH)
    ) u_addr_gen (
      .slot    (slot_q[p*WEIGHT_WRITE_ADDR_WIDTH +: WEIGHT_WRITE_ADDR_WIDTH]),
      .k       (k),
      .addr    (bank_addr[p]),
      .in_range(bank_ok[p])
    );

    assign weight_ram_we[p] = in_write && bank_ok[p];
    assign weight_ram_addr[p*WEIGHT_RAM_ADDR_WIDTH +: WEIGHT_RAM_ADDR_WIDTH] =
      in_write ? bank_addr[p] : '0;
    assign weight_ram_wdata[p*DATA_WIDTH +: DATA_WIDTH] =
      in_write ? data_q[(p*KK + int'(k))*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

endmodule

// File: tb/tb_weight_ram_loader.sv
// Self-checking bench for weight_ram_loader: table of load scenarios plus
// hand-written reset and back-to-back sequences, checked against a per-bank
// queue of expected writes.
module tb_weight_ram_loader;
  localparam int DW = 16, PK = 4, WAW = 4, DEPTH = 128, RAW = 7, KK = 9;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [KK*PK*DW-1:0]   weight_data;
  logic [WAW*PK-1:0]     write_weight_data_addr;
  logic                  weight_data_done;
  logic                  init_weight_ram_ready;
  logic [PK-1:0]         weight_ram_we;
  logic [RAW*PK-1:0]     weight_ram_addr;
  logic [DW*PK-1:0]      weight_ram_wdata;
  logic                  busy;
  logic                  addr_err;

  weight_ram_loader dut (
    .clk                   (clk),
    .rst                   (rst),
    .weight_data           (weight_data),
    .write_weight_data_addr(write_weight_data_addr),
    .weight_data_done      (weight_data_done),
    .init_weight_ram_ready (init_weight_ram_ready),
    .weight_ram_we         (weight_ram_we),
    .weight_ram_addr       (weight_ram_addr),
    .weight_ram_wdata      (weight_ram_wdata),
    .busy                  (busy),
    .addr_err              (addr_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [RAW-1:0] addr;
    logic [DW-1:0]  data;
  } exp_t;

  typedef struct {
    bit          pre_rst;
    int          mode;       // 0: all 3c00, 1: word (p,k) = 16'h00pk, 2: random
    logic [15:0] slots;      // slot of bank p in nibble p
    bit          drop_early; // done falls during WRITE
    int          hold;       // extra ACK cycles with done held high
    bit          exp_err;
  } vec_t;

  exp_t exp_q[PK][$];
  vec_t vecs[6];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic clear_q();
    for (int p = 0; p < PK; p++) exp_q[p].delete();
  endtask

  // Drive a bundle and push the writes it must produce.
  task automatic build(input int mode, input logic [15:0] slots);
    int          s;
    logic [15:0] w;
    write_weight_data_addr = slots;
    for (int p = 0; p < PK; p++) begin
      s = int'(slots[p*4 +: 4]);
      for (int kk = 0; kk < KK; kk++) begin
        case (mode)
          0:       w = 16'h3c00;
          1:       w = {8'h00, 4'(p), 4'(kk)};
          default: w = 16'($urandom);
        endcase
        weight_data[(p*KK + kk)*DW +: DW] = w;
        if (s*KK + KK <= DEPTH) exp_q[p].push_back('{addr: RAW'(s*KK + kk), data: w});
      end
    end
  endtask

  task automatic do_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_q();
  endtask

  // Called at a negedge with the DUT idle; raises done and follows the load.
  task automatic run_req(input string tag, input bit drop_early, input int hold, input bit exp_err);
    int   rdy_at;
    exp_t e;
    rdy_at = 0;
    weight_data_done = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check({tag, "_busy"}, 32'(busy), 32'd1);
        weight_data = {18{$urandom}};
        write_weight_data_addr = 16'($urandom);
      end
      for (int p = 0; p < PK; p++) begin
        if (weight_ram_we[p]) begin
          if (exp_q[p].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_extra_write bank=%0d actual_addr=%h required=none", tag, p,
                     weight_ram_addr[p*RAW +: RAW]);
          end else begin
            e = exp_q[p].pop_front();
            check($sformatf("%s_write_b%0d", tag, p),
                  32'({weight_ram_addr[p*RAW +: RAW], weight_ram_wdata[p*DW +: DW]}),
                  32'({e.addr, e.data}));
          end
        end
      end
      if (drop_early && c == 3) weight_data_done = 1'b0;
      if (rdy_at == 0 && init_weight_ram_ready) begin
        rdy_at = c;
        check({tag, "_latency"}, 32'(c), 32'd10);
      end
      if (rdy_at != 0) begin
        if (c <= rdy_at + hold) begin
          if (c > rdy_at) check({tag, "_ready_hold"}, 32'(init_weight_ram_ready), 32'd1);
          if (c == rdy_at + hold) weight_data_done = 1'b0;
        end else begin
          check({tag, "_ready_fall"}, 32'(init_weight_ram_ready), 32'd0);
          check({tag, "_idle"}, 32'(busy), 32'd0);
          break;
        end
      end
    end
    if (rdy_at == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_ready required=ready", tag);
      weight_data_done = 1'b0;
    end
    for (int p = 0; p < PK; p++)
      check($sformatf("%s_left_b%0d", tag, p), 32'(exp_q[p].size()), 32'd0);
    check({tag, "_addr_err"}, 32'(addr_err), 32'(exp_err));
  endtask

  initial begin
    vecs[0] = '{1'b1, 0, 16'h3210, 1'b0, 0, 1'b0};
    vecs[1] = '{1'b1, 1, 16'h5555, 1'b0, 0, 1'b0};
    vecs[2] = '{1'b1, 2, 16'hC70D, 1'b0, 2, 1'b0};
    vecs[3] = '{1'b1, 1, 16'h3E10, 1'b0, 0, 1'b1};
    vecs[4] = '{1'b0, 0, 16'h0000, 1'b1, 0, 1'b1};
    vecs[5] = '{1'b1, 2, 16'h1234, 1'b1, 0, 1'b0};

    rst = 1'b1;
    weight_data = '0;
    write_weight_data_addr = '0;
    weight_data_done = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_we", 32'(weight_ram_we), 32'd0);
    check("rst_addr", 32'(weight_ram_addr), 32'd0);
    check("rst_wdata_lo", weight_ram_wdata[31:0], 32'd0);
    check("rst_wdata_hi", weight_ram_wdata[63:32], 32'd0);
    check("rst_ready", 32'(init_weight_ram_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr_err", 32'(addr_err), 32'd0);
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].pre_rst) do_rst();
      build(vecs[v].mode, vecs[v].slots);
      run_req($sformatf("vec%0d", v), vecs[v].drop_early, vecs[v].hold, vecs[v].exp_err);
    end

    // Reset in the middle of WRITE, then a clean restart.
    do_rst();
    build(0, 16'h3210);
    weight_data_done = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_we_before", 32'(weight_ram_we), 32'hf);
    rst = 1'b1;
    #1;
    check("midrst_we", 32'(weight_ram_we), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(init_weight_ram_ready), 32'd0);
    weight_data_done = 1'b0;
    clear_q();
    @(negedge clk);
    rst = 1'b0;
    check("midrst_addr_err", 32'(addr_err), 32'd0);
    build(1, 16'h4444);
    run_req("restart", 1'b0, 0, 1'b0);

    // Back-to-back bundles: done re-raised the cycle after ready falls.
    build(1, 16'h0123);
    run_req("b2b_a", 1'b0, 0, 1'b0);
    build(2, 16'h3210);
    run_req("b2b_b", 1'b0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
